// File: rtl/rpm_bcd_convert_if.sv
// Request/response bundle between an RPM source and the BCD converter.
interface rpm_bcd_convert_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 5
);
  logic [BIN_W-1:0]    bin;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd;
  logic                out_valid;
  logic                busy;

  modport master (output bin, in_valid, input in_ready, bcd, out_valid, busy);
  modport slave  (input bin, in_valid, output in_ready, bcd, out_valid, busy);
endinterface

// File: rtl/rpm_bcd_convert.sv
// Serial double-dabble binary-to-BCD converter, one input bit per clock.
// Output digits feed seven-segment decoders; 4'hF marks a blanked digit.
module rpm_bcd_convert #(
  parameter int BIN_W    = 14,
  parameter int DIGITS   = 5,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic              clk,
  input logic              reset,
  rpm_bcd_convert_if.slave conv
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  // Value 0: units digit 0, everything above it blanked (or zero).
  localparam logic [BCD_W-1:0] RST_BCD = BLANK_LZ ? ~BCD_W'(4'hF) : '0;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Every binary input must fit in the digit count, so no overflow path exists.
  if ((64'd1 << BIN_W) > pow10(DIGITS)) begin : g_range_err
    $error("rpm_bcd_convert: DIGITS too small for BIN_W");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [BIN_W-1:0]   shreg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   blanked;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   bcd_q;
  logic               out_valid_q;
  logic               seen_nz;

  // Add 3 to every nibble >= 5 before the shift; nibbles are independent.
  always_comb begin
    adj = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  // Leading-zero blanking from the top digit down; units digit always shown.
  always_comb begin
    blanked = scratch;
    seen_nz = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (scratch[4*k +: 4] != 4'd0) seen_nz = 1'b1;
      else if (!seen_nz && BLANK_LZ) blanked[4*k +: 4] = 4'hF;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: accept in IDLE, BIN_W shift cycles, one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (conv.in_valid) state_next = SHIFT;
      SHIFT:   if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch on accept, add-3/shift in SHIFT, load result in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg       <= '0;
      scratch     <= '0;
      cnt         <= '0;
      bcd_q       <= RST_BCD;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: if (conv.in_valid) begin
          shreg   <= conv.bin;
          scratch <= '0;
          cnt     <= CNT_W'(BIN_W - 1);
        end
        SHIFT: begin
          {scratch, shreg} <= {adj[BCD_W-2:0], shreg, 1'b0};
          cnt              <= cnt - CNT_W'(1);
        end
        DONE: begin
          bcd_q       <= blanked;
          out_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign conv.in_ready  = (state == IDLE);
  assign conv.busy      = (state != IDLE);
  assign conv.bcd       = bcd_q;
  assign conv.out_valid = out_valid_q;
endmodule

// File: tb/tb_rpm_bcd_convert.sv
// Bench for rpm_bcd_convert: blanking and plain instances driven in lockstep,
// expected digits queued on accept and compared when out_valid pulses.
module tb_rpm_bcd_convert;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] bin = '0;
  logic        in_valid = 1'b0;
  bit          started = 1'b0;
  int          checks = 0, errors = 0;
  int          ov1 = 0, ov0 = 0, reqs = 0;
  int          ov_mark;
  logic [19:0] q1[$];
  logic [19:0] q0[$];
  logic [19:0] e1, e0;

  always #5 clk = ~clk;

  rpm_bcd_convert_if #(.BIN_W(14), .DIGITS(5)) c1 ();
  rpm_bcd_convert_if #(.BIN_W(14), .DIGITS(5)) c0 ();
  assign c1.bin = bin;
  assign c1.in_valid = in_valid;
  assign c0.bin = bin;
  assign c0.in_valid = in_valid;

  rpm_bcd_convert #(.BIN_W(14), .DIGITS(5), .BLANK_LZ(1'b1)) u_blank (
    .clk(clk), .reset(reset), .conv(c1));
  rpm_bcd_convert #(.BIN_W(14), .DIGITS(5), .BLANK_LZ(1'b0)) u_plain (
    .clk(clk), .reset(reset), .conv(c0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal digits by division; blanked digits are those above the value's length.
  function automatic logic [19:0] model(input int v, input bit blank);
    logic [19:0] r;
    int x, nd;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    nd = 1;
    x = v / 10;
    while (x > 0) begin nd++; x = x / 10; end
    if (blank) for (int k = nd; k < 5; k++) r[4*k +: 4] = 4'hF;
    return r;
  endfunction

  task automatic push(input int v);
    q1.push_back(model(v, 1'b1));
    q0.push_back(model(v, 1'b0));
    reqs++;
  endtask

  // One full conversion; optionally pokes bin/in_valid mid-SHIFT.
  task automatic do_conv(input int v, input bit poke);
    @(negedge clk);
    bin = 14'(v);
    in_valid = 1'b1;
    chk("ready_idle", c1.in_ready, 1);
    @(posedge clk);
    push(v);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("ready_low", c1.in_ready, 0);
      if (poke && i == 3) begin bin = 14'(v ^ 'h155); in_valid = 1'b1; end
      if (poke && i == 4) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("ready_back", c1.in_ready, 1);
    chk("ready_back_plain", c0.in_ready, 1);
    chk("ov_time", c1.out_valid, 1);
  endtask

  // Scoreboard and invariant monitor.
  always @(negedge clk) begin
    if (started && !reset) begin
      chk("busy_vs_ready", c1.busy, !c1.in_ready);
      chk("busy_vs_ready_plain", c0.busy, !c0.in_ready);
      if (c1.out_valid) begin
        ov1++;
        if (q1.size() == 0) chk("spurious_ov", c1.out_valid, 0);
        else begin e1 = q1.pop_front(); chk("bcd_blank", c1.bcd, e1); end
      end
      if (c0.out_valid) begin
        ov0++;
        if (q0.size() == 0) chk("spurious_ov_plain", c0.out_valid, 0);
        else begin e0 = q0.pop_front(); chk("bcd_plain", c0.bcd, e0); end
      end
    end
  end

  initial begin
    // Reset state
    reset = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", c1.in_ready, 1);
    chk("rst_busy", c1.busy, 0);
    chk("rst_ov", c1.out_valid, 0);
    chk("rst_bcd_blank", c1.bcd, 20'hFFFF0);
    chk("rst_bcd_plain", c0.bcd, 20'h00000);
    in_valid = 1'b0;
    reset = 1'b0;
    started = 1'b1;

    // Zero, then directed values
    do_conv(0, 1'b0);
    chk("zero_blank", c1.bcd, 20'hFFFF0);
    chk("zero_plain", c0.bcd, 20'h00000);
    do_conv(1234, 1'b0);
    chk("v1234", c1.bcd, 20'hF1234);
    do_conv(16383, 1'b0);
    chk("vmax", c1.bcd, 20'h16383);
    do_conv(1000, 1'b0);
    chk("v1000", c1.bcd, 20'hF1000);
    chk("v1000_plain", c0.bcd, 20'h01000);

    // Request during SHIFT is ignored; original value wins
    do_conv(2468, 1'b1);
    chk("poke_result", c1.bcd, 20'hF2468);

    // Back-to-back with in_valid held high
    @(negedge clk);
    ov_mark = ov1;
    bin = 14'd7;
    in_valid = 1'b1;
    @(posedge clk);
    push(7);
    @(negedge clk);
    bin = 14'd9999;
    for (int i = 0; i < 15; i++) begin
      chk("b2b_ready_low", c1.in_ready, 0);
      @(negedge clk);
    end
    chk("b2b_ready_16", c1.in_ready, 1);
    @(posedge clk);
    push(9999);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_accepted", c1.in_ready, 0);
    chk("b2b_bcd7", c1.bcd, 20'hFFFF7);
    repeat (16) @(negedge clk);
    chk("b2b_bcd9999", c1.bcd, 20'hF9999);
    chk("b2b_pulses", ov1 - ov_mark, 2);

    // Reset at the 5th SHIFT cycle aborts the conversion
    @(negedge clk);
    ov_mark = ov1;
    bin = 14'd4321;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", c1.in_ready, 1);
    chk("abort_busy", c1.busy, 0);
    chk("abort_bcd_blank", c1.bcd, 20'hFFFF0);
    chk("abort_bcd_plain", c0.bcd, 20'h00000);
    repeat (20) @(negedge clk);
    chk("abort_no_ov", ov1 - ov_mark, 0);
    do_conv(42, 1'b0);
    chk("after_abort_42", c1.bcd, 20'hFFF42);

    // Sampled sweep: low end, high end, decades, random
    for (int v = 0; v < 40; v++) do_conv(v, 1'b0);
    for (int v = 16344; v <= 16383; v++) do_conv(v, 1'b0);
    for (int v = 1; v <= 16383; v = v * 10) begin
      do_conv(v - 1, 1'b0);
      do_conv(v, 1'b0);
    end
    for (int n = 0; n < 100; n++) do_conv(int'($urandom_range(0, 16383)), 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty_blank", q1.size(), 0);
    chk("queue_empty_plain", q0.size(), 0);
    chk("ov_count_blank", ov1, reqs);
    chk("ov_count_plain", ov0, reqs);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
